// File: rtl/line_stack_array_pkg.sv
`default_nettype none
// ============================================================================
// Module      : line_stack_array_pkg
// Description : Shared defaults and helpers for the line stack array.
//               Provides default geometry (CH, DW, ROWS, MAX_COL, COL_W),
//               a ceil-log2 helper, the register-array index width helper
//               and the buf_out tap slice offset.
// Revision    : 1.0 - initial release
// ============================================================================
package line_stack_array_pkg;

    localparam int LSA_CH      = 2;
    localparam int LSA_DW      = 8;
    localparam int LSA_ROWS    = 2;
    localparam int LSA_MAX_COL = 320;
    localparam int LSA_COL_W   = 9;

    // Ceil-log2; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    // Bits needed to address one row of the register array (at least 1).
    function automatic int idx_w(input int max_col);
        return (max_col > 1) ? clog2(max_col) : 1;
    endfunction

    // LSB of channel c, tap r inside the flattened buf_out bus.
    function automatic int tap_lsb(input int c, input int r, input int rows, input int dw);
        return (c * rows + r) * dw;
    endfunction

endpackage : line_stack_array_pkg
`default_nettype wire

// File: rtl/line_stack_array_if.sv
`default_nettype none
// ============================================================================
// Module      : line_stack_array_if
// Description : Beat/tap bus of the line stack array.
//   clr, en, row_len, buf_in          : producer -> line stack
//   buf_out, tap_vld, out_valid, col_out : line stack -> consumer
//   master modport drives beats, slave modport is the line stack itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface line_stack_array_if
    import line_stack_array_pkg::*;
#(
    parameter int CH    = LSA_CH,
    parameter int DW    = LSA_DW,
    parameter int ROWS  = LSA_ROWS,
    parameter int COL_W = LSA_COL_W
) ();

    logic                    clr;
    logic                    en;
    logic [COL_W-1:0]        row_len;
    logic [CH*DW-1:0]        buf_in;
    logic [CH*ROWS*DW-1:0]   buf_out;
    logic [ROWS-1:0]         tap_vld;
    logic                    out_valid;
    logic [COL_W-1:0]        col_out;

    modport master (
        output clr, en, row_len, buf_in,
        input  buf_out, tap_vld, out_valid, col_out
    );

    modport slave (
        input  clr, en, row_len, buf_in,
        output buf_out, tap_vld, out_valid, col_out
    );

endinterface : line_stack_array_if
`default_nettype wire

// File: rtl/line_stack_array_ch.sv
`default_nettype none
// ============================================================================
// Module      : line_stack_ch
// Description : One channel of the line stack: ROWS x MAX_COL register
//               array plus the registered tap outputs.
//   clk, rst_n : clock, asynchronous active-low reset (taps only)
//   wr         : accepted beat strobe
//   k          : column being read/written this beat
//   pixel_in   : incoming pixel
//   taps       : tap r (r=0 is one row ago) at [r*DW +: DW]
// Revision    : 1.0 - initial release
// ============================================================================
module line_stack_ch
    import line_stack_array_pkg::*;
#(
    parameter int DW      = LSA_DW,
    parameter int ROWS    = LSA_ROWS,
    parameter int MAX_COL = LSA_MAX_COL,
    parameter int IDX_W   = idx_w(LSA_MAX_COL)
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 wr,
    input  wire logic [IDX_W-1:0]     k,
    input  wire logic [DW-1:0]        pixel_in,
    output logic      [ROWS*DW-1:0]   taps
);

    // Contents are deliberately not reset; stale data is masked by tap_vld.
    logic [DW-1:0]             r_mem [ROWS][MAX_COL];
    logic [ROWS-1:0][DW-1:0]   r_tap;

    // Per-column shift register: row 0 takes the new pixel, every older
    // row takes the previous row's pre-write value at the same column.
    always_ff @(posedge clk) begin
        if (wr) begin
            r_mem[0][k] <= pixel_in;
            for (int r = 1; r < ROWS; r++) begin
                r_mem[r][k] <= r_mem[r-1][k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tap <= '0;
        end else if (wr) begin
            for (int r = 0; r < ROWS; r++) begin
                r_tap[r] <= r_mem[r][k];
            end
        end
    end

    assign taps = r_tap;

endmodule : line_stack_ch
`default_nettype wire

// File: rtl/line_stack_array.sv
`default_nettype none
// ============================================================================
// Module      : line_stack_array
// Description : CH-channel vertical window feed. Each accepted beat returns
//               the pixels at the same column from the previous 1..ROWS
//               rows, one cycle later.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : line_stack_array_if.slave (clr/en/row_len/buf_in in,
//           buf_out/tap_vld/out_valid/col_out out)
// Revision    : 1.0 - initial release
// ============================================================================
module line_stack_array
    import line_stack_array_pkg::*;
#(
    parameter int CH      = LSA_CH,
    parameter int DW      = LSA_DW,
    parameter int ROWS    = LSA_ROWS,
    parameter int MAX_COL = LSA_MAX_COL,
    parameter int COL_W   = LSA_COL_W
) (
    input wire logic          clk,
    input wire logic          rst_n,
    line_stack_array_if.slave bus
);

    localparam int                   c_FILL_W  = clog2(ROWS + 1);
    localparam int                   c_IDX_W   = idx_w(MAX_COL);
    localparam logic [COL_W-1:0]     c_MAX_COL = COL_W'(MAX_COL);
    localparam logic [c_FILL_W-1:0]  c_ROWS    = c_FILL_W'(ROWS);

    logic [COL_W-1:0]        r_wr_col;
    logic [c_FILL_W-1:0]     r_row_fill;
    logic [COL_W-1:0]        r_len;
    logic                    r_out_valid;
    logic [COL_W-1:0]        r_col_out;
    logic [ROWS-1:0]         r_tap_vld;

    logic                    w_beat;
    logic                    w_last_col;
    logic [COL_W-1:0]        w_len_next;
    logic [ROWS-1:0]         w_tap_vld;
    logic [CH*ROWS*DW-1:0]   w_buf_out;

    // clr has priority: a beat presented together with clr is dropped.
    assign w_beat     = bus.en & ~bus.clr;
    assign w_last_col = (r_wr_col == r_len - COL_W'(1));
    assign w_len_next = ((bus.row_len == '0) || (bus.row_len > c_MAX_COL)) ? c_MAX_COL
                                                                            : bus.row_len;

    generate
        for (genvar r = 0; r < ROWS; r++) begin : g_vld
            assign w_tap_vld[r] = (r_row_fill > c_FILL_W'(r));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_col    <= '0;
            r_row_fill  <= '0;
            r_len       <= c_MAX_COL;
            r_out_valid <= 1'b0;
            r_col_out   <= '0;
            r_tap_vld   <= '0;
        end else if (bus.clr) begin
            r_wr_col    <= '0;
            r_row_fill  <= '0;
            r_len       <= w_len_next;
            r_out_valid <= 1'b0;
        end else if (bus.en) begin
            r_out_valid <= 1'b1;
            r_col_out   <= r_wr_col;
            r_tap_vld   <= w_tap_vld;
            if (w_last_col) begin
                r_wr_col <= '0;
                if (r_row_fill != c_ROWS) begin
                    r_row_fill <= r_row_fill + c_FILL_W'(1);
                end
            end else begin
                r_wr_col <= r_wr_col + COL_W'(1);
            end
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    generate
        for (genvar c = 0; c < CH; c++) begin : g_ch
            line_stack_ch #(
                .DW      (DW),
                .ROWS    (ROWS),
                .MAX_COL (MAX_COL),
                .IDX_W   (c_IDX_W)
            ) u_ch (
                .clk      (clk),
                .rst_n    (rst_n),
                .wr       (w_beat),
                .k        (r_wr_col[c_IDX_W-1:0]),
                .pixel_in (bus.buf_in[c*DW +: DW]),
                .taps     (w_buf_out[tap_lsb(c, 0, ROWS, DW) +: ROWS*DW])
            );
        end
    endgenerate

    assign bus.buf_out   = w_buf_out;
    assign bus.tap_vld   = r_tap_vld;
    assign bus.out_valid = r_out_valid;
    assign bus.col_out   = r_col_out;

endmodule : line_stack_array
`default_nettype wire

// File: tb/tb_line_stack_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_stack_array
// Description : Self-checking bench for line_stack_array (CH=2, DW=8,
//               ROWS=2, MAX_COL=8). A beat-history model predicts every
//               output: tap r of beat n is the pixel of beat n-(r+1)*len.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_stack_array;

    localparam int CH      = 2;
    localparam int DW      = 8;
    localparam int ROWS    = 2;
    localparam int MAX_COL = 8;
    localparam int COL_W   = 4;
    localparam int HMAX    = 4096;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    line_stack_array_if #(.CH(CH), .DW(DW), .ROWS(ROWS), .COL_W(COL_W)) bus ();

    line_stack_array #(
        .CH(CH), .DW(DW), .ROWS(ROWS), .MAX_COL(MAX_COL), .COL_W(COL_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    int         m_len;
    int         m_n;
    logic [7:0] m_hist [CH][HMAX];
    bit         m_valid;
    logic [3:0] m_col;
    logic [1:0] m_vld;
    logic [7:0] m_tap  [CH][ROWS];
    bit         m_known[CH][ROWS];

    task automatic model_reset();
        m_len   = MAX_COL;
        m_n     = 0;
        m_valid = 1'b0;
        m_col   = '0;
        m_vld   = '0;
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < ROWS; r++) begin
                m_tap[c][r]   = '0;
                m_known[c][r] = 1'b1;
            end
    endtask

    task automatic model_cycle(input bit c_clr, input bit c_en, input logic [3:0] rl,
                               input logic [7:0] d0, input logic [7:0] d1);
        if (c_clr) begin
            m_len   = (rl == 0 || rl > MAX_COL) ? MAX_COL : int'(rl);
            m_n     = 0;
            m_valid = 1'b0;
        end else if (c_en) begin
            for (int r = 0; r < ROWS; r++) begin
                bit v;
                v = (m_n >= (r + 1) * m_len);
                m_vld[r] = v;
                for (int c = 0; c < CH; c++) begin
                    m_known[c][r] = v;
                    if (v) m_tap[c][r] = m_hist[c][m_n - (r + 1) * m_len];
                end
            end
            m_col = 4'(m_n % m_len);
            m_hist[0][m_n] = d0;
            m_hist[1][m_n] = d1;
            m_n++;
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_outputs(input string sc);
        check($sformatf("%s out_valid", sc), 32'(bus.out_valid), 32'(m_valid));
        check($sformatf("%s col_out", sc),   32'(bus.col_out),   32'(m_col));
        check($sformatf("%s tap_vld", sc),   32'(bus.tap_vld),   32'(m_vld));
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < ROWS; r++)
                if (m_known[c][r])
                    check($sformatf("%s ch%0d tap%0d", sc, c, r),
                          32'(bus.buf_out[(c*ROWS + r)*DW +: DW]), 32'(m_tap[c][r]));
    endtask

    task automatic cycle(input string sc, input bit c_clr, input bit c_en,
                         input logic [3:0] rl, input logic [7:0] d0, input logic [7:0] d1);
        bus.clr     = c_clr;
        bus.en      = c_en;
        bus.row_len = rl;
        bus.buf_in  = {d1, d0};
        @(posedge clk);
        #1;
        model_cycle(c_clr, c_en, rl, d0, d1);
        check_outputs(sc);
    endtask

    task automatic check_zero(input string sc);
        check($sformatf("%s rst out_valid", sc), 32'(bus.out_valid), 32'd0);
        check($sformatf("%s rst col_out", sc),   32'(bus.col_out),   32'd0);
        check($sformatf("%s rst tap_vld", sc),   32'(bus.tap_vld),   32'd0);
        check($sformatf("%s rst buf_out", sc),   32'(bus.buf_out),   32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.clr     = 1'b0;
        bus.en      = 1'b0;
        bus.row_len = '0;
        bus.buf_in  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("init");
        rst_n = 1'b1;

        // 1: row length 4, ramp stream
        cycle("s1", 1, 0, 4'd4, 8'h0, 8'h0);
        for (int i = 0; i < 12; i++) cycle("s1", 0, 1, 4'd4, 8'(8'h10 + i), 8'(8'h80 + i));

        // 2: out-of-range lengths fall back to MAX_COL
        cycle("s2a", 1, 0, 4'd0, 8'h0, 8'h0);
        for (int i = 0; i < 12; i++) cycle("s2a", 0, 1, 4'd0, 8'($urandom), 8'($urandom));
        cycle("s2b", 1, 0, 4'd12, 8'h0, 8'h0);
        for (int i = 0; i < 12; i++) cycle("s2b", 0, 1, 4'd3, 8'($urandom), 8'($urandom));

        // 3: en gap mid-row at column 2
        cycle("s3", 1, 0, 4'd4, 8'h0, 8'h0);
        for (int i = 0; i < 6; i++) cycle("s3", 0, 1, 4'd4, 8'($urandom), 8'($urandom));
        for (int i = 0; i < 3; i++) cycle("s3", 0, 0, 4'd4, 8'($urandom), 8'($urandom));
        for (int i = 0; i < 8; i++) cycle("s3", 0, 1, 4'd4, 8'($urandom), 8'($urandom));

        // 4: clr together with en at column 3 of row 2
        cycle("s4", 1, 0, 4'd4, 8'h0, 8'h0);
        for (int i = 0; i < 7; i++) cycle("s4", 0, 1, 4'd4, 8'($urandom), 8'($urandom));
        cycle("s4", 1, 1, 4'd4, 8'($urandom), 8'($urandom));
        for (int i = 0; i < 6; i++) cycle("s4", 0, 1, 4'd4, 8'($urandom), 8'($urandom));

        // 5: asynchronous reset between edges
        for (int i = 0; i < 3; i++) cycle("s5", 0, 1, 4'd4, 8'($urandom), 8'($urandom));
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("s5 async");
        model_reset();
        bus.en = 1'b0;
        @(posedge clk);
        #1;
        check_zero("s5 held");
        rst_n = 1'b1;
        cycle("s5", 1, 0, 4'd4, 8'h0, 8'h0);
        for (int i = 0; i < 12; i++) cycle("s5", 0, 1, 4'd4, 8'(8'h10 + i), 8'(8'h80 + i));

        // 6: channel independence
        cycle("s6", 1, 0, 4'd8, 8'h0, 8'h0);
        for (int i = 0; i < 24; i++) cycle("s6", 0, 1, 4'd8, 8'hAA, 8'(i));

        // 7: random lengths, en gaps and occasional clr
        for (int it = 0; it < 4; it++) begin
            cycle("rnd", 1, 0, 4'($urandom_range(0, 15)), 8'h0, 8'h0);
            for (int i = 0; i < 60; i++)
                cycle("rnd", ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
                      4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_line_stack_array
`default_nettype wire
